fifo_wptr_full_ctrl: RTL and testbench

- Write-domain pointer and flag controller for a dual-clock FIFO; generalised successor to the team's first write-pointer block.
- Keeps a binary and a registered Gray write pointer and produces the RAM write address/enable.
- Detects full correctly against the Gray read pointer already synchronised into wclk.
- Adds fill level, a programmable almost-full flag and an optional sticky overflow flag.

---
 rtl/fifo_wptr_full_ctrl.sv | 86 ++++++++
 tb/tb_fifo_wptr_full_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_wptr_full_ctrl.sv
// Write-domain pointer/flag controller for a dual-clock FIFO: binary + Gray write
// pointer, full, fill level, almost-full; sticky overflow when FIFO_WPTR_OVF_EN is defined.
module fifo_wptr_full_ctrl #(
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   wq2_rptr,
  input  logic                  wclr_ovf,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [ADDR_WIDTH:0]   wlevel,
  output logic                  woverflow
);
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AFULL_TH = PW'(AFULL_THRESH);

  logic [PW-1:0]         wbin_q, wbin_d, wgray_d, rbin, level_d;
  logic [PW-1:0]         wptr_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic                  wfull_q, wfull_d, afull_q, afull_d;
  logic [PW-1:0]         wlevel_q;
  logic                  ovf_q;

  assign wen     = winc & ~wfull_q;
  assign wbin_d  = wbin_q + PW'(wen);
  assign wgray_d = wbin_d ^ (wbin_d >> 1);

  // Gray-to-binary of the synchronised read pointer
  always_comb begin
    rbin = '0;
    rbin[PW-1] = wq2_rptr[PW-1];
    for (int i = PW - 2; i >= 0; i--)
      rbin[i] = rbin[i+1] ^ wq2_rptr[i];
  end

  // Full when the next write pointer equals the read pointer with its top two Gray bits inverted
  assign wfull_d = (wgray_d == {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], wq2_rptr[ADDR_WIDTH-2:0]});
  assign level_d = wbin_d - rbin;
  assign afull_d = (level_d >= AFULL_TH);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      waddr_q  <= '0;
      wfull_q  <= 1'b0;
      afull_q  <= 1'b0;
      wlevel_q <= '0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wgray_d;
      waddr_q  <= wbin_d[ADDR_WIDTH-1:0];
      wfull_q  <= wfull_d;
      afull_q  <= afull_d;
      wlevel_q <= level_d;
    end
  end

`ifdef FIFO_WPTR_OVF_EN
  logic ovf_d;
  // A fresh overflow takes priority over a clear on the same edge
  assign ovf_d = (winc & wfull_q) | (ovf_q & ~wclr_ovf);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) ovf_q <= 1'b0;
    else         ovf_q <= ovf_d;
  end
`else
  logic unused_clr;
  assign unused_clr = wclr_ovf;
  assign ovf_q      = 1'b0;
`endif

  assign waddr        = waddr_q;
  assign wptr         = wptr_q;
  assign wfull        = wfull_q;
  assign walmost_full = afull_q;
  assign wlevel       = wlevel_q;
  assign woverflow    = ovf_q;
endmodule

// File: tb/tb_fifo_wptr_full_ctrl.sv
// Scoreboard bench for fifo_wptr_full_ctrl (ADDR_WIDTH=4, AFULL_THRESH=12).
module tb_fifo_wptr_full_ctrl;
  logic       wclk = 1'b0;
  logic       wrst_n = 1'b0;
  logic       winc = 1'b0;
  logic [4:0] wq2_rptr = '0;
  logic       wclr_ovf = 1'b0;
  logic       wen, wfull, walmost_full, woverflow;
  logic [3:0] waddr;
  logic [4:0] wptr, wlevel;

  fifo_wptr_full_ctrl #(.ADDR_WIDTH(4), .AFULL_THRESH(12)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wq2_rptr(wq2_rptr), .wclr_ovf(wclr_ovf),
    .wen(wen), .waddr(waddr), .wptr(wptr), .wfull(wfull), .walmost_full(walmost_full),
    .wlevel(wlevel), .woverflow(woverflow)
  );

  always #5 wclk = ~wclk;

  typedef struct packed {
    logic       wen;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       wfull;
    logic       afull;
    logic [4:0] lvl;
    logic       ovf;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state (value after the most recent edge)
  logic [4:0] mbin = '0, rb = '0, mlvl = '0;
  logic       mfull = 1'b0, mafull = 1'b0, movf = 1'b0;

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every falling edge compares the DUT against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge wclk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("wen", wen, e.wen);
        chk("waddr", waddr, e.waddr);
        chk("wptr", wptr, e.wptr);
        chk("wfull", wfull, e.wfull);
        chk("walmost_full", walmost_full, e.afull);
        chk("wlevel", wlevel, e.lvl);
        chk("woverflow", woverflow, e.ovf);
        chk("full_vs_level", wfull, (wlevel == 5'd16));
      end
    end
  end

  function automatic exp_t cur_exp(input logic w);
    exp_t e;
    e.wen = w & ~mfull; e.waddr = mbin[3:0]; e.wptr = gray(mbin);
    e.wfull = mfull; e.afull = mafull; e.lvl = mlvl; e.ovf = movf;
    return e;
  endfunction

  // Called at posedge+1: drive inputs, queue the expectation for this cycle, advance the model
  task automatic step(input logic w, input logic [4:0] rbin_in, input logic clr);
    logic [4:0] nbin, nlvl;
    logic       nfull, novf;
    rb = rbin_in;
    winc = w; wq2_rptr = gray(rb); wclr_ovf = clr;
    q.push_back(cur_exp(w));
    nbin  = mbin + {4'd0, (w & ~mfull)};
    nlvl  = nbin - rb;
    nfull = (nlvl == 5'd16);
`ifdef FIFO_WPTR_OVF_EN
    novf = (w & mfull) | (movf & ~clr);
`else
    novf = 1'b0;
`endif
    @(posedge wclk); #1;
    mbin = nbin; mlvl = nlvl; mfull = nfull; mafull = (nlvl >= 5'd12); movf = novf;
  endtask

  task automatic do_reset();
    wrst_n = 1'b0; winc = 1'b1; #1;
    chk("rst_waddr", waddr, 0);
    chk("rst_wptr", wptr, 0);
    chk("rst_wlevel", wlevel, 0);
    chk("rst_wfull", wfull, 0);
    mbin = '0; mlvl = '0; mfull = 1'b0; mafull = 1'b0; movf = 1'b0; rb = '0;
    wq2_rptr = '0;
    q.push_back(cur_exp(1'b1));
    @(posedge wclk); #1;
    wrst_n = 1'b1; winc = 1'b0;
  endtask

  initial begin
    @(posedge wclk); #1;
    do_reset();

    // Fill: 16 writes against an idle reader
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 5'd0, 1'b0);
      if (i == 11) chk("afull_before_12", walmost_full, 0);
      if (i == 12) chk("afull_at_12", walmost_full, 1);
    end
    chk("fill_wfull", wfull, 1);
    chk("fill_wlevel", wlevel, 16);
    chk("fill_waddr", waddr, 0);
    chk("fill_wptr", wptr, 5'b11000);

    // Write while full is dropped
    winc = 1'b1; #1; chk("full_wen", wen, 0);
    step(1'b1, 5'd0, 1'b0);
    chk("full_wptr_hold", wptr, 5'b11000);
    chk("full_wlevel_hold", wlevel, 16);
`ifdef FIFO_WPTR_OVF_EN
    chk("ovf_set", woverflow, 1);
    step(1'b0, 5'd0, 1'b0);
    chk("ovf_hold", woverflow, 1);
    step(1'b0, 5'd0, 1'b1);
    chk("ovf_clr", woverflow, 0);
`else
    step(1'b0, 5'd0, 1'b1);
    chk("ovf_off", woverflow, 0);
`endif

    // Drain: read pointer advances to 4 then 5
    step(1'b0, 5'd4, 1'b0);
    chk("drain_wfull", wfull, 0);
    chk("drain_wlevel12", wlevel, 12);
    chk("drain_afull12", walmost_full, 1);
    step(1'b0, 5'd5, 1'b0);
    chk("drain_wlevel11", wlevel, 11);
    chk("drain_afull11", walmost_full, 0);

    // Reset mid-operation, between edges
    do_reset();

    // Wrap: walk wbin to 30 with a trailing reader, then cross the modulo boundary
    for (int i = 0; i < 30; i++)
      step(1'b1, (mbin >= 5'd2) ? mbin - 5'd2 : 5'd0, 1'b0);
    step(1'b0, 5'd28, 1'b0);
    step(1'b1, 5'd28, 1'b0);
    chk("wrap_wptr31", wptr, 5'b10000);
    chk("wrap_waddr15", waddr, 15);
    step(1'b1, 5'd28, 1'b0);
    chk("wrap_wptr0", wptr, 5'b00000);
    chk("wrap_waddr0", waddr, 0);
    chk("wrap_wlevel", wlevel, 4);
    chk("wrap_wfull", wfull, 0);

    // Random writes with a monotonic reader that never passes the writer
    for (int i = 0; i < 10000; i++) begin
      logic [4:0] nrb;
      nrb = rb;
      if (nrb != mbin && $urandom_range(0, 2) == 0) nrb = nrb + 5'd1;
      step(1'($urandom_range(0, 1)), nrb, ($urandom_range(0, 7) == 0));
    end

    winc = 1'b0;
    repeat (3) @(negedge wclk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_queue: got %0d expected 0 pending", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
